ofm_pack_writer: RTL

- Collects the per-PE 8-bit OFM results that the convolution core emits on an all-PE valid strobe.
- Buffers each result set in a beat FIFO, then serialises it into 32-bit words with computed OFM word addresses for the OFM memory/DMA.
- Parametrised successor of the fixed 16-PE OFM output path: variable PE count, FIFO depth and OFM geometry; adds backpressure, address generation, overflow tracking and a completion flag.

---
 rtl/ofm_pack_writer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ofm_pack_writer.sv
// ofm_pack_writer: gathers the per-PE OFM bytes of each all-valid beat into a beat FIFO.
// It serialises each buffered beat into N_PE/4 32-bit words, each with its OFM word address.
// Build option: define OFM_PACK_RELU_EN to clamp negative bytes to zero before packing.
module ofm_pack_writer #(
    parameter int unsigned N_PE       = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIM_W      = 8,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [DIM_W-1:0]    i_ofm_w,
    input  logic [DIM_W-1:0]    i_ofm_c,
    input  logic [N_PE-1:0]     i_valid,
    input  logic [8*N_PE-1:0]   i_ofm_in,
    output logic                o_in_ready,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [31:0]         o_out_data,
    output logic [ADDR_W-1:0]   o_out_addr,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overflow
);

    localparam int unsigned WORDS  = N_PE / 4;
    localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PIX_W  = 2 * DIM_W;
    localparam int unsigned AW2    = ADDR_W + 2;
    localparam int unsigned BEAT_W = 8 * N_PE;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic                  r_done;
    logic                  w_done_d;

    // Layer configuration and position counters
    logic [PIX_W-1:0]      r_npix;
    logic [DIM_W-1:0]      r_ofm_c;
    logic [PIX_W-1:0]      r_pix;
    logic [DIM_W-1:0]      r_ch;
    logic                  r_overflow;

    // Beat FIFO; each entry carries its first word address
    logic [BEAT_W-1:0]     r_mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_mem_addr [FIFO_DEPTH];
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;
    logic [PTR_W:0]        r_lptr;
    logic                  r_full;
    logic [PTR_W:0]        w_count_d;

    // Serialiser output register
    logic [WORD_W-1:0]     r_word;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [31:0]           r_out_data;
    logic [ADDR_W-1:0]     r_out_addr;

    logic                  w_beat;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_last_pix;
    logic                  w_last_tile;
    logic [AW2-1:0]        w_elem;
    logic [ADDR_W-1:0]     w_base;
    logic                  w_empty;
    logic                  w_avail;
    logic                  w_hs;
    logic                  w_pop;
    logic                  w_load;
    logic [BEAT_W-1:0]     w_sel_data;
    logic [31:0]           w_word;

    function automatic logic [7:0] f_act(input logic [7:0] b);
`ifdef OFM_PACK_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    assign w_beat      = &i_valid;
    assign w_push      = (r_state == StRun) && w_beat && !r_full;
    assign w_drop      = (r_state == StRun) && w_beat && r_full;
    assign w_last_pix  = (r_pix == (r_npix - PIX_W'(1)));
    assign w_last_tile = ((32'(r_ch) + N_PE) >= 32'(r_ofm_c));

    // Element offset pixel*OFM_C + channel base, kept ADDR_W+2 bits wide before the /4
    assign w_elem = AW2'((PIX_W + DIM_W)'(r_pix) * (PIX_W + DIM_W)'(r_ofm_c)) + AW2'(r_ch);
    assign w_base = ADDR_W'(w_elem >> 2);

    assign w_empty = (r_rptr == r_wptr);
    // r_lptr runs ahead of r_rptr by at most one beat: the beat whose words are still loading
    assign w_avail = (r_lptr != r_wptr);
    assign w_hs    = r_out_valid && i_out_ready;
    assign w_pop   = w_hs && r_out_last;
    assign w_load  = w_avail && (!r_out_valid || i_out_ready);

    assign w_sel_data = r_mem_data[r_lptr[PTR_W-1:0]];

    // Pack the selected word of the loading beat, lowest PE byte in the top lane
    always_comb begin
        w_word = '0;
        for (int j = 0; j < 4; j++) begin
            w_word[31-8*j -: 8] = f_act(w_sel_data[8*(4*int'(r_word) + j) +: 8]);
        end
    end

    // FIFO occupancy after this cycle's push/pop, used to register the full flag
    always_comb begin
        w_count_d = r_wptr - r_rptr;
        if (w_push) w_count_d = w_count_d + (PTR_W + 1)'(1);
        if (w_pop)  w_count_d = w_count_d - (PTR_W + 1)'(1);
    end

    // FSM state register plus registered completion pulse
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_done  <= w_done_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_d = (i_ofm_w == '0) ? StDrain : StRun;
            end
            StRun: begin
                if (w_push && w_last_pix && w_last_tile) w_state_d = StDrain;
            end
            StDrain: begin
                if (w_empty) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy     = (r_state != StIdle);
        o_in_ready = (r_state == StRun) && !r_full;
        w_done_d   = (r_state == StDrain) && w_empty;
    end

    // Config latch, pixel/tile counters and sticky overflow
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_npix     <= '0;
            r_ofm_c    <= '0;
            r_pix      <= '0;
            r_ch       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == StIdle && i_start) begin
                r_npix     <= PIX_W'(i_ofm_w) * PIX_W'(i_ofm_w);
                r_ofm_c    <= i_ofm_c;
                r_pix      <= '0;
                r_ch       <= '0;
                r_overflow <= 1'b0;
            end else if (w_push) begin
                if (w_last_pix) begin
                    r_pix <= '0;
                    r_ch  <= r_ch + DIM_W'(N_PE);
                end else begin
                    r_pix <= r_pix + PIX_W'(1);
                end
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // FIFO pointers and registered full flag
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W + 1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PTR_W + 1)'(1);
            r_full <= (w_count_d == (PTR_W + 1)'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_data[r_wptr[PTR_W-1:0]] <= i_ofm_in;
            r_mem_addr[r_wptr[PTR_W-1:0]] <= w_base;
        end
    end

    // Serialiser: load the next word whenever the output register is free or handshaking
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_lptr      <= '0;
            r_word      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_addr  <= r_mem_addr[r_lptr[PTR_W-1:0]] + ADDR_W'(r_word);
            r_out_last  <= (r_word == WORD_W'(WORDS - 1));
            if (r_word == WORD_W'(WORDS - 1)) begin
                r_word <= '0;
                r_lptr <= r_lptr + (PTR_W + 1)'(1);
            end else begin
                r_word <= r_word + WORD_W'(1);
            end
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;

endmodule
